// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared constants, fetch-state encoding and IF/ID record type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [31:0] C_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    // Modulo-2^32 increment; alignment bits pass through untouched.
    function automatic logic [31:0] pc_plus4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// ============================================================================
// Module : ifid_reg
// Brief  : IF/ID pipeline register with flush, load, bubble and hold.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  i_load,
    input  logic  i_flush,
    input  logic  i_bubble,
    input  ifid_t i_data,
    output ifid_t o_q
);

    ifid_t r_q;

    // Flush beats load beats bubble; with none asserted the register holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'd0};
        end else if (i_flush) begin
            r_q.valid <= 1'b0;
            r_q.instr <= NOP_INSTR;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_bubble) begin
            r_q.valid <= 1'b0;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module : if_stage
// Brief  : Mini-MIPS instruction fetch: memory handshake FSM, next_pc mux,
//          IF/ID register, stall and redirect handling.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        fetch_busy
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_req_addr;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_hold_pc4;

    logic [31:0]  w_fetch_addr;
    logic [31:0]  w_pc4;
    logic [31:0]  w_next_pc;
    logic         w_load;
    logic         w_flush;
    logic         w_bubble;
    logic         w_hold_load;
    logic         w_hold_clr;
    logic         w_req_load;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    assign w_fetch_addr = (r_state == ST_REQ) ? pc : r_req_addr;
    assign w_pc4        = pc_plus4(w_fetch_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_REQ;
            r_req_addr   <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc4   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_load) begin
                r_req_addr <= pc;
            end
            if (w_hold_clr) begin
                r_hold_instr <= 32'd0;
                r_hold_pc4   <= 32'd0;
            end else if (w_hold_load) begin
                r_hold_instr <= imem_rdata;
                r_hold_pc4   <= w_pc4;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_next_pc   = pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_bubble    = 1'b0;
        w_hold_load = 1'b0;
        w_hold_clr  = 1'b0;
        w_req_load  = 1'b0;
        w_ifid_d    = '{valid: 1'b1, instr: imem_rdata, pc4: w_pc4};

        if (redirect_valid) begin
            w_next_pc  = redirect_target;
            w_flush    = 1'b1;
            w_hold_clr = 1'b1;
            // An issued request that has not yet been acked must still drain.
            if (((r_state == ST_WAIT) || (r_state == ST_DISCARD)) && !imem_ack) begin
                w_state_nxt = ST_DISCARD;
            end else begin
                w_state_nxt = ST_REQ;
            end
        end else begin
            case (r_state)
                ST_REQ, ST_WAIT: begin
                    if (imem_ack) begin
                        if (!stall) begin
                            w_load      = 1'b1;
                            w_next_pc   = w_pc4;
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_hold_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_req_load  = (r_state == ST_REQ);
                        w_bubble    = !stall;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_load      = 1'b1;
                        w_ifid_d    = '{valid: 1'b1, instr: r_hold_instr, pc4: r_hold_pc4};
                        w_next_pc   = pc_plus4(pc);
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    w_bubble = !stall;
                    if (imem_ack) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_REQ;
                end
            endcase
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_flush  (w_flush),
        .i_bubble (w_bubble),
        .i_data   (w_ifid_d),
        .o_q      (w_ifid_q)
    );

    assign next_pc    = reset ? RESET_PC : w_next_pc;
    assign imem_req   = !reset && (r_state != ST_HOLD);
    assign imem_addr  = w_fetch_addr;
    assign fetch_busy = (r_state != ST_REQ);
    assign ifid_valid = w_ifid_q.valid;
    assign ifid_instr = w_ifid_q.instr;
    assign ifid_pc4   = w_ifid_q.pc4;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module : tb_if_stage
// Brief  : Directed self-checking bench for if_stage with a PC register model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        fetch_busy;

    logic        zw;
    logic        ack_man;
    logic [31:0] rdata_man;
    int          checks;
    int          errors;

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc4        (ifid_pc4),
        .fetch_busy      (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: loads unconditionally every edge.
    always @(posedge clk) pc <= next_pc;

    // Zero-wait memory acks in the request cycle and returns addr + 0x10000000.
    assign imem_ack   = zw ? imem_req : ack_man;
    assign imem_rdata = zw ? (imem_addr + 32'h1000_0000) : rdata_man;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; zw = 1'b1; ack_man = 1'b0; rdata_man = 32'd0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (next_pc !== 32'h0040_0000) begin errors++; $display("FAIL rst_next_pc got=%h exp=%h", next_pc, 32'h0040_0000); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got=%h exp=0", ifid_instr); end
        checks++; if (ifid_pc4 !== 32'd0) begin errors++; $display("FAIL rst_pc4 got=%h exp=0", ifid_pc4); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", fetch_busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (next_pc !== (32'h0040_0004 + 32'(4 * k))) begin errors++; $display("FAIL zw_next_pc%0d got=%h exp=%h", k, next_pc, 32'h0040_0004 + 32'(4 * k)); end
            @(negedge clk);
        end
        checks++; if (ifid_pc4 !== 32'h0040_000C) begin errors++; $display("FAIL zw_pc4 got=%h exp=%h", ifid_pc4, 32'h0040_000C); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got=%b exp=1", ifid_valid); end
        checks++; if (ifid_instr !== 32'h1040_0008) begin errors++; $display("FAIL zw_instr got=%h exp=%h", ifid_instr, 32'h1040_0008); end
    endtask

    task automatic test_wait();
        do_reset();
        zw = 1'b0; ack_man = 1'b1; rdata_man = 32'h1111_1111;
        @(negedge clk);
        ack_man = 1'b0; #1;
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL wait_addr0 got=%h exp=%h", imem_addr, 32'h0040_0004); end
        checks++; if (next_pc !== 32'h0040_0004) begin errors++; $display("FAIL wait_npc0 got=%h exp=%h", next_pc, 32'h0040_0004); end
        @(negedge clk); #1;
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL wait_addr1 got=%h exp=%h", imem_addr, 32'h0040_0004); end
        checks++; if (next_pc !== 32'h0040_0004) begin errors++; $display("FAIL wait_npc1 got=%h exp=%h", next_pc, 32'h0040_0004); end
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL wait_busy got=%b exp=1", fetch_busy); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL wait_bubble got=%b exp=0", ifid_valid); end
        @(negedge clk);
        ack_man = 1'b1; rdata_man = 32'h2402_0005; #1;
        checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL wait_addr2 got=%h exp=%h", imem_addr, 32'h0040_0004); end
        checks++; if (next_pc !== 32'h0040_0008) begin errors++; $display("FAIL wait_npc_ack got=%h exp=%h", next_pc, 32'h0040_0008); end
        @(negedge clk);
        checks++; if (ifid_instr !== 32'h2402_0005) begin errors++; $display("FAIL wait_instr got=%h exp=%h", ifid_instr, 32'h2402_0005); end
        checks++; if (ifid_pc4 !== 32'h0040_0008) begin errors++; $display("FAIL wait_pc4 got=%h exp=%h", ifid_pc4, 32'h0040_0008); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL wait_busy_end got=%b exp=0", fetch_busy); end
    endtask

    task automatic test_stall();
        ack_man = 1'b1; rdata_man = 32'h8C08_0004; stall = 1'b1; #1;
        checks++; if (next_pc !== 32'h0040_0008) begin errors++; $display("FAIL stall_npc_ack got=%h exp=%h", next_pc, 32'h0040_0008); end
        @(negedge clk);
        ack_man = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (ifid_instr !== 32'h2402_0005) begin errors++; $display("FAIL stall_hold_instr%0d got=%h exp=%h", k, ifid_instr, 32'h2402_0005); end
            checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid%0d got=%b exp=1", k, ifid_valid); end
            checks++; if (next_pc !== 32'h0040_0008) begin errors++; $display("FAIL stall_npc%0d got=%h exp=%h", k, next_pc, 32'h0040_0008); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got=%b exp=0", k, imem_req); end
            checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL stall_busy%0d got=%b exp=1", k, fetch_busy); end
            @(negedge clk);
        end
        stall = 1'b0; #1;
        checks++; if (next_pc !== 32'h0040_000C) begin errors++; $display("FAIL stall_release_npc got=%h exp=%h", next_pc, 32'h0040_000C); end
        @(negedge clk);
        checks++; if (ifid_instr !== 32'h8C08_0004) begin errors++; $display("FAIL stall_release_instr got=%h exp=%h", ifid_instr, 32'h8C08_0004); end
        checks++; if (ifid_pc4 !== 32'h0040_000C) begin errors++; $display("FAIL stall_release_pc4 got=%h exp=%h", ifid_pc4, 32'h0040_000C); end
    endtask

    task automatic test_redirect_wait();
        @(negedge clk);
        redirect_valid = 1'b1; redirect_target = 32'h0040_0100; #1;
        checks++; if (next_pc !== 32'h0040_0100) begin errors++; $display("FAIL rdw_npc got=%h exp=%h", next_pc, 32'h0040_0100); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL rdw_busy got=%b exp=1", fetch_busy); end
        checks++; if (imem_addr !== 32'h0040_000C) begin errors++; $display("FAIL rdw_old_addr got=%h exp=%h", imem_addr, 32'h0040_000C); end
        checks++; if (next_pc !== 32'h0040_0100) begin errors++; $display("FAIL rdw_npc_discard got=%h exp=%h", next_pc, 32'h0040_0100); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rdw_valid got=%b exp=0", ifid_valid); end
        ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
        @(negedge clk);
        ack_man = 1'b0; #1;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rdw_drop_valid got=%b exp=0", ifid_valid); end
        checks++; if (ifid_instr === 32'hDEAD_BEEF) begin errors++; $display("FAIL rdw_drop_instr got=%h exp=not DEADBEEF", ifid_instr); end
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL rdw_new_addr got=%h exp=%h", imem_addr, 32'h0040_0100); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL rdw_busy_end got=%b exp=0", fetch_busy); end
    endtask

    task automatic test_redirect_stall();
        ack_man = 1'b1; rdata_man = 32'h1234_5678;
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL rds_pre_valid got=%b exp=1", ifid_valid); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0040_0200; #1;
        checks++; if (next_pc !== 32'h0040_0200) begin errors++; $display("FAIL rds_npc got=%h exp=%h", next_pc, 32'h0040_0200); end
        @(negedge clk);
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rds_valid got=%b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL rds_instr got=%h exp=0", ifid_instr); end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0; ack_man = 1'b1; rdata_man = 32'hA0A0_A0A0; #1;
        checks++; if (next_pc !== 32'd0) begin errors++; $display("FAIL wrap_npc got=%h exp=0", next_pc); end
        @(negedge clk);
        ack_man = 1'b0;
        checks++; if (ifid_pc4 !== 32'd0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", ifid_pc4); end
        checks++; if (ifid_instr !== 32'hA0A0_A0A0) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", ifid_instr, 32'hA0A0_A0A0); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1;
        @(negedge clk);
        checks++; if (fetch_busy !== 1'b1 || ifid_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b%b exp=11", fetch_busy, ifid_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", ifid_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got=%b exp=0", imem_req); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", fetch_busy); end
        checks++; if (next_pc !== 32'h0040_0000) begin errors++; $display("FAIL arst_npc got=%h exp=%h", next_pc, 32'h0040_0000); end
        stall = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero_wait();
        test_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage for the Mini-MIPS core. It sits directly downstream of the PC register: it consumes `pc`, issues the instruction-memory request, and produces the `next_pc` that the PC register loads on every clock edge.
- It owns the IF/ID pipeline register, absorbs variable-latency memory responses, and handles decode stalls and branch/jump redirects.
- The PC register loads unconditionally every cycle, so this block must drive `next_pc = pc` whenever the fetch does not advance.

Parameters:
- RESET_PC, 32'h00400000, text-segment start; value `next_pc` reports while reset is asserted.
- NOP_INSTR, 32'h00000000, value loaded into `ifid_instr` on reset and on flush.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pc  in  32  current PC from the PC register
- next_pc  out  32  PC for the next cycle, to the PC register (combinational)
- imem_req  out  1  fetch request; held high until ack
- imem_addr  out  32  fetch address; stable while imem_req is high
- imem_ack  in  1  read data valid this cycle; may assert in the same cycle as req
- imem_rdata  in  32  instruction word, valid when ack is high
- stall  in  1  decode cannot accept; IF/ID holds
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_target  in  32  new PC when redirect_valid is high
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  fetched instruction
- ifid_pc4  out  32  address of the fetched instruction + 4
- fetch_busy  out  1  high in WAIT, HOLD or DISCARD

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: state = REQ, ifid_valid = 0, ifid_instr = NOP_INSTR, ifid_pc4 = 0, req_addr = 0, hold_buf = 0.
- Reset outputs: while reset is high, imem_req is forced to 0 and next_pc = RESET_PC.
- imem_addr: equals pc in REQ; equals the latched req_addr in WAIT and DISCARD.
- Decision priority: redirect_valid > imem_ack > stall.
- REQ state:
  - imem_req = 1.
  - ack=1 and stall=0: IF/ID <= {1, rdata, pc+4}; next_pc = pc+4; stay in REQ.
  - ack=1 and stall=1: hold_buf <= {rdata, pc+4}; next_pc = pc; go to HOLD.
  - ack=0: req_addr <= pc; next_pc = pc; go to WAIT.
- WAIT state:
  - imem_req = 1; next_pc = pc.
  - On ack, apply the same rules as REQ, using req_addr in place of pc.
- HOLD state:
  - imem_req = 0; next_pc = pc.
  - When stall drops: IF/ID <= hold_buf with valid=1; next_pc = pc+4; go to REQ.
- DISCARD state:
  - imem_req = 1 with the old req_addr; next_pc = pc.
  - On ack: drop the data; go to REQ.
- Redirect (any state):
  - next_pc = redirect_target; ifid_valid <= 0; ifid_instr <= NOP_INSTR; hold_buf is invalidated.
  - From WAIT with ack=0: go to DISCARD, because the outstanding request must complete.
  - From WAIT with ack=1, from REQ, or from HOLD: go to REQ.
  - From DISCARD with ack=0: stay in DISCARD, with next_pc = redirect_target. With ack=1: go to REQ.
  - redirect_valid together with stall=1: the flush wins and IF/ID is cleared.
- IF/ID update:
  - stall=1 and no redirect: IF/ID holds its value.
  - stall=0 and no instruction delivered this cycle: ifid_valid <= 0 (bubble).
- Throughput: with zero-wait memory, one instruction per cycle; ifid_valid rises at the edge after the ack.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 0. Alignment is not checked; pc[1:0] passes through unchanged.
- Reset asserted mid-fetch: all state is cleared immediately; a late ack after reset release is ignored while imem_req = 0 (memory must tolerate this).

Decomposition:
- Shared package `mips_pkg`:
  - RESET_PC and NOP_INSTR constants.
  - Fetch-state enum {REQ, WAIT, HOLD, DISCARD}.
  - IF/ID struct {valid, instr[31:0], pc4[31:0]}.
- Sub-module `ifid_reg`: the IF/ID pipeline register with load, hold and flush controls.
- The FSM and next_pc mux stay in if_stage.

Test Plan:
- Reset, then zero-wait memory (ack tied to req), pc starting at 32'h00400000 → next_pc steps by 4 each cycle; after 3 edges ifid_pc4 = 32'h0040000C and ifid_valid stays 1.
- Memory acks 2 cycles after req → imem_addr stays 32'h00400004 throughout; next_pc = pc until the ack; fetch_busy = 1 during WAIT; ifid_instr = rdata after the ack.
- stall=1 arriving with ack (rdata = 32'h8C080004) for 3 cycles → IF/ID unchanged, next_pc = pc; after stall drops, ifid_instr = 32'h8C080004 and next_pc = pc+4.
- redirect_valid with target 32'h00400100 while in WAIT → DISCARD, late ack data dropped, ifid_valid = 0; the next fetch uses address 32'h00400100.
- redirect_valid and stall both high → ifid_valid = 0, ifid_instr = 0, next_pc = redirect_target.
- pc = 32'hFFFFFFFC fetched → next_pc = 0 and ifid_pc4 = 0. Async reset asserted mid-WAIT → ifid_valid = 0 and imem_req = 0 immediately, without waiting for a clock edge.
